pll_lock_supervisor: RTL and testbench
======================================

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: PLL reset pulse length in refclk cycles (min 1).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 50000: max cycles to wait for lock per attempt (1 ms at 50 MHz).
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before release.
REQ-004 SHALL have parameter MAX_RETRY, default 3: consecutive timed-out attempts tolerated before FAIL.
REQ-005 SHALL have port refclk  input  1  sole clock, 50 MHz reference.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port pll_locked  input  1  PLL lock indicator, asynchronous to refclk.
REQ-008 SHALL have port pll_rst  output  1  reset driven to the PLL rst input, active-high.
REQ-009 SHALL have port rst_out  output  1  synchronous active-high reset for downstream logic.
REQ-010 SHALL have port ready  output  1  high only in RUN.
REQ-011 SHALL have port fail  output  1  high only in FAIL.
REQ-012 SHALL have port lost_cnt  output  8  lock-loss events seen in RUN; saturates at 255.

Function
REQ-013 SHALL pass pll_locked through a 2-flop synchronizer; all decisions use the second-stage output (lk_s), giving 2-cycle input latency.
REQ-014 SHALL implement FSM states RESET, WAIT_LOCK, STABLE, RUN, FAIL, all outputs registered.
REQ-015 RESET: pll_rst=1 for exactly RST_CYCLES cycles, then WAIT_LOCK with the timer cleared.
REQ-016 WAIT_LOCK: pll_rst=0; lk_s=1 -> STABLE with counter cleared; timer reaching LOCK_TIMEOUT with lk_s=0 -> retry++ and RESET, or FAIL if the incremented retry exceeds MAX_RETRY.
REQ-017 STABLE: counts consecutive lk_s=1 cycles; lk_s=0 -> WAIT_LOCK (timer cleared, retry unchanged); count reaching STABLE_CYCLES -> RUN and retry cleared to 0.
REQ-018 RUN: rst_out=0, ready=1; lk_s=0 -> lost_cnt++ (saturating) and RESET.
REQ-019 FAIL: pll_rst=1, rst_out=1, fail=1; exit only via rst.
REQ-020 rst_out SHALL be 1 in every state except RUN, and SHALL deassert on the first cycle ready=1.
REQ-021 When timeout and lock arrive in the same cycle, lock SHALL win (go STABLE).
REQ-022 Counter widths SHALL be sized by $clog2 of their parameter +1; no wrap-around is permitted.

Reset
REQ-023 On rst: state=RESET, all counters and retry cleared, synchronizer flops=0, pll_rst=1, rst_out=1, ready=0, fail=0, lost_cnt=0.
REQ-024 rst asserted mid-operation (any state, including FAIL) SHALL take effect on the next edge and restart the full RESET pulse.
REQ-025 The RESET pulse length SHALL count from the first cycle after rst deasserts.

Structure
REQ-026 State encoding typedef and default parameter constants SHALL live in a shared package pll_sup_pkg.
REQ-027 The 2-flop synchronizer SHALL be the one sub-module, sync_2ff, reusable elsewhere.
REQ-028 The supervisor SHALL contain no other instances and no derived clocks.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2)
REQ-029 Nominal: pll_locked rises 5 cycles after rst release and holds -> pll_rst high exactly 4 cycles; ready=1, rst_out=0 at 2+8 cycles after the lock edge (±1 for synchronizer alignment, checked exactly).
REQ-030 Glitch: lock high 5 cycles, low 1, high again -> returns to WAIT_LOCK, STABLE restarts, RUN is reached only after 8 further consecutive locked cycles.
REQ-031 Never lock -> three 4-cycle pll_rst pulses separated by 20-cycle waits, then fail=1, pll_rst=1, rst_out=1 held until rst.
REQ-032 In RUN, drop lock 300 times with re-lock each time -> lost_cnt saturates at 255; rst_out reasserts within 3 cycles of each drop.
REQ-033 rst pulsed in STABLE and in FAIL -> all outputs equal reset values next cycle; a fresh 4-cycle pll_rst pulse follows.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// -----------------------------------------------------------------------------
// pll_sup_pkg
// Shared definitions for the PLL lock supervisor: supervisor state encoding,
// default timing parameters and a counter-width helper.
// -----------------------------------------------------------------------------
package pll_sup_pkg;

  // Defaults sized for a 50 MHz reference clock.
  localparam int unsigned DEF_RST_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 50000;  // 1 ms at 50 MHz
  localparam int unsigned DEF_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_MAX_RETRY     = 3;

  localparam int unsigned LOST_W = 8;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_sup_state_e;

  // One bit more than $clog2 so a counter can always hold its own limit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return $clog2(limit) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single-bit level crossing into i_clk.
// Ports:
//   i_clk  - destination clock
//   i_rst  - synchronous active-high reset, clears both stages to 0
//   i_d    - asynchronous input level
//   o_q    - synchronized level, two i_clk cycles behind i_d
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
// Sequences a PLL out of reset, waits for a stable lock and only then releases
// the downstream reset. Lock timeouts retry the PLL reset a bounded number of
// times before parking in FAIL; a lock loss while running restarts the
// sequence and is counted.
// Ports:
//   refclk     - sole clock (50 MHz reference)
//   rst        - synchronous active-high reset
//   pll_locked - PLL lock indicator, asynchronous to refclk
//   pll_rst    - active-high reset to the PLL (RESET and FAIL)
//   rst_out    - active-high reset for downstream logic, low only in RUN
//   ready      - high only in RUN
//   fail       - high only in FAIL
//   lost_cnt   - lock losses seen in RUN, saturating at 255
// The FSM state is held in r_state (type pll_sup_state_e) for observation.
// -----------------------------------------------------------------------------
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRY     = DEF_MAX_RETRY
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              pll_locked,
  output logic              pll_rst,
  output logic              rst_out,
  output logic              ready,
  output logic              fail,
  output logic [LOST_W-1:0] lost_cnt
);

  localparam int unsigned RST_W = cnt_width(RST_CYCLES);
  localparam int unsigned TMO_W = cnt_width(LOCK_TIMEOUT);
  localparam int unsigned STB_W = cnt_width(STABLE_CYCLES);
  localparam int unsigned RTY_W = cnt_width(MAX_RETRY);

  // Terminal counts: each phase lasts exactly its parameter in cycles,
  // counting from 0 on the cycle the phase is entered.
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  logic w_lk_s;

  pll_sup_state_e    r_state;
  logic [RST_W-1:0]  r_rst_cnt;
  logic [TMO_W-1:0]  r_timer;
  logic [STB_W-1:0]  r_stab_cnt;
  logic [RTY_W-1:0]  r_retry;
  logic [LOST_W-1:0] r_lost_cnt;
  logic              r_pll_rst;
  logic              r_rst_out;
  logic              r_ready;
  logic              r_fail;

  pll_sup_state_e    w_state_nxt;
  logic [RST_W-1:0]  w_rst_cnt_nxt;
  logic [TMO_W-1:0]  w_timer_nxt;
  logic [STB_W-1:0]  w_stab_cnt_nxt;
  logic [RTY_W-1:0]  w_retry_nxt;
  logic [LOST_W-1:0] w_lost_cnt_nxt;

  sync_2ff u_sync_lock (
    .i_clk (refclk),
    .i_rst (rst),
    .i_d   (pll_locked),
    .o_q   (w_lk_s)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_rst_cnt_nxt  = r_rst_cnt;
    w_timer_nxt    = r_timer;
    w_stab_cnt_nxt = r_stab_cnt;
    w_retry_nxt    = r_retry;
    w_lost_cnt_nxt = r_lost_cnt;

    case (r_state)
      ST_RESET: begin
        if (r_rst_cnt == RST_LAST) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_timer_nxt = '0;
        end else begin
          w_rst_cnt_nxt = r_rst_cnt + 1'b1;
        end
      end

      ST_WAIT_LOCK: begin
        // Lock is tested first so it wins over a coincident timeout.
        if (w_lk_s) begin
          w_state_nxt    = ST_STABLE;
          w_stab_cnt_nxt = '0;
        end else if (r_timer == TMO_LAST) begin
          // retry+1 > MAX_RETRY written as retry >= MAX_RETRY: no overflow.
          if (r_retry >= RTY_MAX) begin
            w_state_nxt = ST_FAIL;
          end else begin
            w_retry_nxt   = r_retry + 1'b1;
            w_state_nxt   = ST_RESET;
            w_rst_cnt_nxt = '0;
          end
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end

      ST_STABLE: begin
        if (!w_lk_s) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_timer_nxt = '0;
        end else if (r_stab_cnt == STB_LAST) begin
          w_state_nxt = ST_RUN;
          w_retry_nxt = '0;
        end else begin
          w_stab_cnt_nxt = r_stab_cnt + 1'b1;
        end
      end

      ST_RUN: begin
        if (!w_lk_s) begin
          if (r_lost_cnt != {LOST_W{1'b1}}) begin
            w_lost_cnt_nxt = r_lost_cnt + 1'b1;
          end
          w_state_nxt   = ST_RESET;
          w_rst_cnt_nxt = '0;
        end
      end

      ST_FAIL: begin
        // Terminal until rst.
      end

      default: begin
        w_state_nxt   = ST_RESET;
        w_rst_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state    <= ST_RESET;
      r_rst_cnt  <= '0;
      r_timer    <= '0;
      r_stab_cnt <= '0;
      r_retry    <= '0;
      r_lost_cnt <= '0;
      r_pll_rst  <= 1'b1;
      r_rst_out  <= 1'b1;
      r_ready    <= 1'b0;
      r_fail     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rst_cnt  <= w_rst_cnt_nxt;
      r_timer    <= w_timer_nxt;
      r_stab_cnt <= w_stab_cnt_nxt;
      r_retry    <= w_retry_nxt;
      r_lost_cnt <= w_lost_cnt_nxt;
      // Outputs decoded from the next state so they align with r_state.
      r_pll_rst  <= (w_state_nxt == ST_RESET) || (w_state_nxt == ST_FAIL);
      r_rst_out  <= (w_state_nxt != ST_RUN);
      r_ready    <= (w_state_nxt == ST_RUN);
      r_fail     <= (w_state_nxt == ST_FAIL);
    end
  end

  assign pll_rst  = r_pll_rst;
  assign rst_out  = r_rst_out;
  assign ready    = r_ready;
  assign fail     = r_fail;
  assign lost_cnt = r_lost_cnt;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_supervisor
// Directed bench for pll_lock_supervisor with RST_CYCLES=4, LOCK_TIMEOUT=20,
// STABLE_CYCLES=8, MAX_RETRY=2. A deadline-based model predicts the outputs
// after every clock edge; literal expectations pin pulse lengths, latencies
// and saturation.
// -----------------------------------------------------------------------------
module tb_pll_lock_supervisor;
  import pll_sup_pkg::*;

  localparam int RST_C = 4;
  localparam int TMO_C = 20;
  localparam int STB_C = 8;
  localparam int RTY_C = 2;
  localparam int W     = 12;

  localparam int PH_RESET  = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_STABLE = 2;
  localparam int PH_RUN    = 3;
  localparam int PH_FAIL   = 4;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       pll_rst;
  logic       rst_out;
  logic       ready;
  logic       fail;
  logic [7:0] lost_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  always #5 refclk = ~refclk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  pll_lock_supervisor #(
    .RST_CYCLES    (RST_C),
    .LOCK_TIMEOUT  (TMO_C),
    .STABLE_CYCLES (STB_C),
    .MAX_RETRY     (RTY_C)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .rst_out    (rst_out),
    .ready      (ready),
    .fail       (fail),
    .lost_cnt   (lost_cnt)
  );

  // ---------------- model ----------------
  // Each phase ends at an absolute edge number (m_end); the synchronized lock
  // is the input sampled two edges earlier.
  int           cyc = 0;
  logic         last_rst = 1'b1;
  logic         lk_hist[$];
  int           m_phase = PH_RESET;
  int           m_end = 0;
  int           m_retry = 0;
  int           m_lost = 0;
  logic         m_rst, m_lk, m_lk_s;
  logic [W-1:0] exp_q[$];

  always @(posedge refclk) begin
    m_rst = rst;
    m_lk  = pll_locked;
    cyc++;
    if (m_rst) begin
      lk_hist.delete();
      lk_hist.push_back(1'b0);
      lk_hist.push_back(1'b0);
      m_phase = PH_RESET;
      m_end   = cyc + RST_C;
      m_retry = 0;
      m_lost  = 0;
    end else begin
      m_lk_s = lk_hist[lk_hist.size() - 2];
      lk_hist.push_back(m_lk);
      if (lk_hist.size() > 4) lk_hist.delete(0);
      case (m_phase)
        PH_RESET: if (cyc == m_end) begin
          m_phase = PH_WAIT;
          m_end   = cyc + TMO_C;
        end
        PH_WAIT: if (m_lk_s) begin
          m_phase = PH_STABLE;
          m_end   = cyc + STB_C;
        end else if (cyc == m_end) begin
          if (m_retry + 1 > RTY_C) begin
            m_phase = PH_FAIL;
          end else begin
            m_retry = m_retry + 1;
            m_phase = PH_RESET;
            m_end   = cyc + RST_C;
          end
        end
        PH_STABLE: if (!m_lk_s) begin
          m_phase = PH_WAIT;
          m_end   = cyc + TMO_C;
        end else if (cyc == m_end) begin
          m_phase = PH_RUN;
          m_retry = 0;
        end
        PH_RUN: if (!m_lk_s) begin
          if (m_lost < 255) m_lost = m_lost + 1;
          m_phase = PH_RESET;
          m_end   = cyc + RST_C;
        end
        default: ;
      endcase
    end
    exp_q.push_back({(m_phase == PH_RESET) || (m_phase == PH_FAIL),
                     m_phase != PH_RUN, m_phase == PH_RUN, m_phase == PH_FAIL,
                     8'(m_lost)});
    last_rst = m_rst;
  end

  // ---------------- scoreboard / compare ----------------
  logic [W-1:0] sb_exp, sb_got;
  int hi_run = 0;
  int lo_run = 0;
  int pulse_q[$];
  int gap_q[$];

  always @(negedge refclk) begin
    if (exp_q.size() > 0) begin
      sb_exp = exp_q.pop_front();
      sb_got = {pll_rst, rst_out, ready, fail, lost_cnt};
      n_checks++;
      if (sb_got !== sb_exp) begin
        n_errors++;
        $display("FAIL outputs @edge %0d: got pll_rst=%b rst_out=%b ready=%b fail=%b lost=%0d, expected pll_rst=%b rst_out=%b ready=%b fail=%b lost=%0d",
                 cyc, sb_got[11], sb_got[10], sb_got[9], sb_got[8], sb_got[7:0],
                 sb_exp[11], sb_exp[10], sb_exp[9], sb_exp[8], sb_exp[7:0]);
      end
      // Run lengths of pll_rst high (pulses) and low (waits) since last rst.
      if (last_rst) begin
        hi_run = 1;
        lo_run = 0;
        pulse_q.delete();
        gap_q.delete();
      end else if (pll_rst) begin
        if (lo_run > 0) begin
          gap_q.push_back(lo_run);
          lo_run = 0;
        end
        hi_run++;
      end else begin
        if (hi_run > 0) begin
          pulse_q.push_back(hi_run);
          hi_run = 0;
        end
        lo_run++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pll_rst"}, int'(pll_rst), 1);
    check({tag, "_rst_out"}, int'(rst_out), 1);
    check({tag, "_ready"},   int'(ready),   0);
    check({tag, "_fail"},    int'(fail),    0);
    check({tag, "_lost"},    int'(lost_cnt), 0);
  endtask

  task automatic wait_ready(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge refclk);
      if (ready === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("ready_timeout", 0, 1);
  endtask

  task automatic wait_fail(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge refclk);
      if (fail === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("fail_timeout", 0, 1);
  endtask

  function automatic int q_at(input int q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return -1;
  endfunction

  // ---------------- stimulus ----------------
  int at, mark, seen;

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b0;
    cycles(3);
    check_reset_vals("reset");

    // Nominal: lock 5 cycles after release; ready 10 edges after lock sample.
    rst = 1'b0;
    cycles(5);
    pll_locked = 1'b1;
    mark = cyc + 1;
    wait_ready(60, at);
    check("nom_ready_latency", at - mark, 10);
    check("nom_rst_out_low", int'(rst_out), 0);
    check("nom_pulse_len", q_at(pulse_q, 0), 4);
    check("nom_pulse_count", pulse_q.size(), 1);
    cycles(5);
    check("nom_ready_hold", int'(ready), 1);

    // Glitch: 5 locked samples, 1 low, then locked again.
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    pll_locked = 1'b1;
    cycles(5);
    pll_locked = 1'b0;
    cycles(1);
    pll_locked = 1'b1;
    mark = cyc + 1;
    wait_ready(60, at);
    check("glitch_ready_latency", at - mark, 10);

    // rst while in STABLE.
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    cycles(6);
    check("in_stable_state", int'(dut.r_state), int'(ST_STABLE));
    rst = 1'b1;
    cycles(1);
    check_reset_vals("rst_in_stable");
    rst = 1'b0;
    mark = cyc;
    wait_ready(60, at);
    check("stable_restart_latency", at - mark, 13);
    check("stable_restart_pulse", q_at(pulse_q, 0), 4);

    // Never lock: three 4-cycle pulses, three 20-cycle waits, then FAIL.
    pll_locked = 1'b0;
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    mark = cyc;
    wait_fail(150, at);
    check("fail_latency", at - mark, 72);
    cycles(2);
    check("fail_pulse_count", pulse_q.size(), 3);
    check("fail_gap_count", gap_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("fail_pulse%0d_len", i), q_at(pulse_q, i), 4);
      check($sformatf("fail_gap%0d_len", i), q_at(gap_q, i), 20);
    end
    pll_locked = 1'b1;
    cycles(10);
    check("fail_held", int'(fail), 1);
    check("fail_pll_rst", int'(pll_rst), 1);
    check("fail_rst_out", int'(rst_out), 1);
    check("fail_ready", int'(ready), 0);

    // rst while in FAIL.
    pll_locked = 1'b0;
    rst = 1'b1;
    cycles(1);
    check_reset_vals("rst_in_fail");
    rst = 1'b0;
    cycles(8);
    check("fail_restart_pulse", q_at(pulse_q, 0), 4);
    check("fail_restart_fail_low", int'(fail), 0);

    // 300 lock losses in RUN, re-locking each time.
    pll_locked = 1'b1;
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    wait_ready(60, at);
    for (int i = 1; i <= 300; i++) begin
      pll_locked = 1'b0;
      seen = 0;
      for (int k = 0; k < 3; k++) begin
        @(negedge refclk);
        if (rst_out === 1'b1) seen = 1;
      end
      check($sformatf("drop%0d_rst_out", i), seen, 1);
      pll_locked = 1'b1;
      wait_ready(60, at);
      if (i == 1)   check("lost_first", int'(lost_cnt), 1);
      if (i == 255) check("lost_at_255", int'(lost_cnt), 255);
    end
    check("lost_saturated", int'(lost_cnt), 255);

    cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
